// File: rtl/shift_reg_n.sv
// ---------------------------------------------------------------------------
// shift_reg_n
//
// Parametrised multi-mode shift/rotate register. A parallel word is loaded,
// or shifted/rotated by a programmable distance. The register moves one bit
// position per enabled clock, so a distance of N costs N cycles instead of a
// full barrel shifter. A start/busy/done handshake sequences each operation.
// A serial port carries the bit shifted out and accepts serial insertion.
//
// Parameters
//   WIDTH       register width in bits (power of two, >= 4)
//   AMT_W       derived, log2(WIDTH), width of the shift amount
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-low; clears all state immediately
//   enable      global advance; low freezes all state and blocks start
//   start       operation request, sampled in IDLE while enable is high
//   op          000 NOP, 001 LOAD, 010 SLL, 011 SRL, 100 SRA,
//               101 ROL, 110 ROR, 111 SIN (shift left, insert serial_in)
//   amount      number of single-bit steps, 0..WIDTH-1
//   data_in     parallel value for LOAD
//   serial_in   bit inserted at bit 0 by SIN, sampled on each step
//   data_out    register contents
//   serial_out  bit shifted or rotated out by the most recent step
//   busy        a multi-step operation is in progress
//   done        one-cycle pulse when an operation completes
// ---------------------------------------------------------------------------
module shift_reg_n #(
    parameter int WIDTH = 8,
    localparam int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [AMT_W-1:0] amount,
    input  logic [WIDTH-1:0] data_in,
    input  logic             serial_in,
    output logic [WIDTH-1:0] data_out,
    output logic             serial_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_LOAD = 3'b001,
        OP_SLL  = 3'b010,
        OP_SRL  = 3'b011,
        OP_SRA  = 3'b100,
        OP_ROL  = 3'b101,
        OP_ROR  = 3'b110,
        OP_SIN  = 3'b111
    } op_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state,      state_n;
    op_t              op_q,       op_n;
    logic [AMT_W-1:0] cnt,        cnt_n;
    logic [WIDTH-1:0] data_q,     data_n;
    logic             serial_q,   serial_n;
    logic             busy_q,     busy_n;
    logic             done_q,     done_n;

    logic [WIDTH-1:0] step_data;
    logic             step_bit;
    op_t              op_in;

    assign op_in      = op_t'(op);

    assign data_out   = data_q;
    assign serial_out = serial_q;
    assign busy       = busy_q;
    assign done       = done_q;

    // State register. Every output comes straight from a flop here, so
    // nothing on the input side reaches an output within the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            op_q     <= OP_NOP;
            cnt      <= '0;
            data_q   <= '0;
            serial_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_n;
            op_q     <= op_n;
            cnt      <= cnt_n;
            data_q   <= data_n;
            serial_q <= serial_n;
            busy_q   <= busy_n;
            done_q   <= done_n;
        end
    end

    // One single-bit step of the latched operation, along with the bit
    // that leaves the register. Non-shift codes never reach SHIFT, so the
    // default (hold) arm is never used there.
    always_comb begin
        step_data = data_q;
        step_bit  = serial_q;
        case (op_q)
            OP_SLL: begin
                step_data = {data_q[WIDTH-2:0], 1'b0};
                step_bit  = data_q[WIDTH-1];
            end
            OP_SRL: begin
                step_data = {1'b0, data_q[WIDTH-1:1]};
                step_bit  = data_q[0];
            end
            OP_SRA: begin
                step_data = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
                step_bit  = data_q[0];
            end
            OP_ROL: begin
                step_data = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
                step_bit  = data_q[WIDTH-1];
            end
            OP_ROR: begin
                step_data = {data_q[0], data_q[WIDTH-1:1]};
                step_bit  = data_q[0];
            end
            OP_SIN: begin
                step_data = {data_q[WIDTH-2:0], serial_in};
                step_bit  = data_q[WIDTH-1];
            end
            default: begin
                step_data = data_q;
                step_bit  = serial_q;
            end
        endcase
    end

    // Next-state logic. done defaults low so the pulse lasts exactly one
    // cycle even while enable is low; everything else defaults to hold,
    // which is also the full-stall behaviour when enable is low.
    always_comb begin
        state_n  = state;
        op_n     = op_q;
        cnt_n    = cnt;
        data_n   = data_q;
        serial_n = serial_q;
        busy_n   = busy_q;
        done_n   = 1'b0;

        if (enable) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        case (op_in)
                            OP_NOP: begin
                                data_n = data_q;
                            end
                            OP_LOAD: begin
                                data_n = data_in;
                                done_n = 1'b1;
                            end
                            default: begin
                                // A zero distance completes at once; otherwise
                                // only latch here, the first step is taken on
                                // the following enabled edge.
                                if (amount == '0) begin
                                    done_n = 1'b1;
                                end else begin
                                    op_n    = op_in;
                                    cnt_n   = amount;
                                    busy_n  = 1'b1;
                                    state_n = SHIFT;
                                end
                            end
                        endcase
                    end
                end
                SHIFT: begin
                    data_n   = step_data;
                    serial_n = step_bit;
                    cnt_n    = cnt - AMT_W'(1);
                    // The step taking cnt to zero is the last one.
                    if (cnt == AMT_W'(1)) begin
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_reg_n.sv
// ---------------------------------------------------------------------------
// tb_shift_reg_n
//
// Self-checking bench for shift_reg_n at WIDTH=8. A reference model keeps the
// expected register word and serial bit as plain integers and advances them
// with arithmetic (multiply/divide by two, modulo) for each operation.
// Directed scenarios are followed by a randomized operation mix.
// ---------------------------------------------------------------------------
module tb_shift_reg_n;

    localparam int WIDTH = 8;
    localparam int AMT_W = 3;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_LOAD = 3'd1;
    localparam logic [2:0] OP_SLL  = 3'd2;
    localparam logic [2:0] OP_SRL  = 3'd3;
    localparam logic [2:0] OP_SRA  = 3'd4;
    localparam logic [2:0] OP_ROL  = 3'd5;
    localparam logic [2:0] OP_ROR  = 3'd6;
    localparam logic [2:0] OP_SIN  = 3'd7;

    logic             clk;
    logic             reset;
    logic             enable;
    logic             start;
    logic [2:0]       op;
    logic [AMT_W-1:0] amount;
    logic [WIDTH-1:0] data_in;
    logic             serial_in;
    logic [WIDTH-1:0] data_out;
    logic             serial_out;
    logic             busy;
    logic             done;

    int check_cnt = 0;
    int pass_cnt  = 0;
    int model_d   = 0;
    int model_s   = 0;

    shift_reg_n #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .start      (start),
        .op         (op),
        .amount     (amount),
        .data_in    (data_in),
        .serial_in  (serial_in),
        .data_out   (data_out),
        .serial_out (serial_out),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are then sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic checkState(input string tag, input logic busy_e,
                              input logic done_e);
        checkOutput({tag, "/data"},   32'(data_out),   32'(model_d));
        checkOutput({tag, "/serial"}, 32'(serial_out), 32'(model_s));
        checkOutput({tag, "/busy"},   32'(busy),       32'(busy_e));
        checkOutput({tag, "/done"},   32'(done),       32'(done_e));
    endtask

    task automatic applyStimulus(input logic st, input logic [2:0] o,
                                 input int amt, input int din);
        start     = st;
        op        = o;
        amount    = AMT_W'(amt);
        data_in   = WIDTH'(din);
        serial_in = 1'($urandom_range(0, 1));
    endtask

    // One step of an operation on an 8-bit value held as an integer.
    function automatic void model_step(input logic [2:0] o, input int sin);
        int d;
        d = model_d;
        case (o)
            OP_SLL: begin model_d = (d * 2) % 256;             model_s = d / 128; end
            OP_SRL: begin model_d = d / 2;                     model_s = d % 2;   end
            OP_SRA: begin model_d = d / 2 + (d >= 128 ? 128 : 0); model_s = d % 2; end
            OP_ROL: begin model_d = (d * 2) % 256 + d / 128;   model_s = d / 128; end
            OP_ROR: begin model_d = d / 2 + (d % 2) * 128;     model_s = d % 2;   end
            OP_SIN: begin model_d = (d * 2) % 256 + sin;       model_s = d / 128; end
            default: begin end
        endcase
    endfunction

    task automatic do_load(input int v);
        applyStimulus(1'b1, OP_LOAD, $urandom_range(0, 7), v);
        tick();
        start   = 1'b0;
        model_d = v;
        checkState("load", 1'b0, 1'b1);
    endtask

    // Runs one shift operation to completion. stall_at/intrude_at give the
    // step before which enable drops for two cycles / a LOAD start is
    // pushed in (0 = none). sin_fix < 0 means random serial_in.
    task automatic run_shift(input logic [2:0] o, input int amt,
                             input int stall_at, input int intrude_at,
                             input int sin_fix);
        int sin;
        applyStimulus(1'b1, o, amt, $urandom_range(0, 255));
        tick();
        start = 1'b0;
        if (amt == 0) begin
            checkState("amt0", 1'b0, 1'b1);
            return;
        end
        checkState("accept", 1'b1, 1'b0);
        for (int j = 1; j <= amt; j++) begin
            if (j == stall_at) begin
                enable = 1'b0;
                repeat (2) begin
                    serial_in = 1'($urandom_range(0, 1));
                    tick();
                    checkState("stall", 1'b1, 1'b0);
                end
                enable = 1'b1;
            end
            if (j == intrude_at) begin
                start   = 1'b1;
                op      = OP_LOAD;
                amount  = AMT_W'($urandom_range(0, 7));
                data_in = WIDTH'($urandom_range(0, 255));
            end
            sin       = (sin_fix < 0) ? int'($urandom_range(0, 1)) : sin_fix;
            serial_in = 1'(sin);
            model_step(o, sin);
            tick();
            start = 1'b0;
            checkState("step", 1'(j < amt), 1'(j == amt));
        end
    endtask

    initial begin
        logic [2:0] r_op;
        reset     = 1'b0;
        enable    = 1'b1;
        applyStimulus(1'b0, OP_NOP, 0, 0);

        // Reset state after the clock has run with reset held.
        tick();
        checkState("reset", 1'b0, 1'b0);
        reset = 1'b1;

        // LOAD A5 then SLL 3: 4A, 94, 28, serial_out 1 at the end.
        do_load(8'hA5);
        run_shift(OP_SLL, 3, 0, 0, -1);
        checkOutput("sll3_value",  32'(data_out),   32'h28);
        checkOutput("sll3_serial", 32'(serial_out), 32'h1);

        // done drops at the next edge even with enable low.
        do_load(8'h3C);
        enable = 1'b0;
        tick();
        checkOutput("done_clear_disabled", 32'(done), 32'h0);
        enable = 1'b1;

        // Asynchronous reset between edges clears everything at once.
        #2 reset = 1'b0;
        #1;
        model_d = 0;
        model_s = 0;
        checkState("async_reset", 1'b0, 1'b0);
        @(negedge clk) reset = 1'b1;

        do_load(8'h96);
        run_shift(OP_SRA, 2, 0, 0, -1);
        checkOutput("sra2_value",  32'(data_out),   32'hE5);
        checkOutput("sra2_serial", 32'(serial_out), 32'h1);
        do_load(8'h96);
        run_shift(OP_SRL, 2, 0, 0, -1);
        checkOutput("srl2_value", 32'(data_out), 32'h25);

        do_load(8'h81);
        run_shift(OP_ROR, 1, 0, 0, -1);
        checkOutput("ror1_value",  32'(data_out),   32'hC0);
        checkOutput("ror1_serial", 32'(serial_out), 32'h1);
        do_load(8'h81);
        run_shift(OP_ROL, 7, 0, 0, -1);
        checkOutput("rol7_value", 32'(data_out), 32'hC0);

        do_load(8'h00);
        run_shift(OP_SIN, 4, 0, 0, 1);
        checkOutput("sin4_value", 32'(data_out), 32'h0F);
        do_load(8'h00);
        run_shift(OP_SIN, 4, 3, 0, 1);
        checkOutput("sin4_stall_value", 32'(data_out), 32'h0F);

        // NOP leaves everything alone and raises no done.
        applyStimulus(1'b1, OP_NOP, 3, 8'hFF);
        tick();
        start = 1'b0;
        checkState("nop", 1'b0, 1'b0);

        // LOAD request while busy is ignored.
        do_load(8'h01);
        run_shift(OP_SLL, 5, 0, 2, -1);
        checkOutput("sll5_intrude_value", 32'(data_out), 32'h20);

        // Back-to-back: start in the done cycle is accepted at once.
        do_load(8'h01);
        run_shift(OP_SLL, 5, 0, 0, -1);
        run_shift(OP_SRL, 2, 0, 0, -1);
        checkOutput("b2b_value", 32'(data_out), 32'h08);

        // Reset after step 2 of SLL 5 aborts; a fresh operation then works.
        do_load(8'h01);
        applyStimulus(1'b1, OP_SLL, 5, 0);
        tick();
        start = 1'b0;
        checkState("abort_accept", 1'b1, 1'b0);
        repeat (2) begin
            model_step(OP_SLL, 0);
            tick();
            checkState("abort_step", 1'b1, 1'b0);
        end
        #2 reset = 1'b0;
        #1;
        model_d = 0;
        model_s = 0;
        checkState("abort_reset", 1'b0, 1'b0);
        @(negedge clk) reset = 1'b1;
        do_load(8'h01);
        run_shift(OP_SLL, 5, 0, 0, -1);
        checkOutput("after_abort_value", 32'(data_out), 32'h20);

        // Randomized mix of operations, distances, stalls and intrusions.
        for (int i = 0; i < 40; i++) begin
            r_op = 3'($urandom_range(0, 7));
            if (r_op == OP_LOAD) begin
                do_load($urandom_range(0, 255));
            end else if (r_op == OP_NOP) begin
                applyStimulus(1'b1, OP_NOP, $urandom_range(0, 7), $urandom_range(0, 255));
                tick();
                start = 1'b0;
                checkState("rnd_nop", 1'b0, 1'b0);
            end else begin
                run_shift(r_op, $urandom_range(0, 7), $urandom_range(0, 7),
                          $urandom_range(0, 7), -1);
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/shift_reg_n.md
# shift_reg_n

Parametrised multi-mode shift/rotate register and the WIDTH-generic successor of the 8-bit `shift_reg2`. It loads a parallel word or shifts it by a programmable amount, one bit position per enabled clock. A start/busy/done handshake sequences each operation, and a serial port carries the bit shifted out and accepts serial insertion. It sits in the shifter datapath wherever a variable-distance or serialising shift is needed and a full barrel shifter is too costly.

## Interface
- `WIDTH`, 8, register width in bits; power of two, ≥ 4.
- `AMT_W`, derived localparam = log2(WIDTH), width of the shift amount.
- `clk` input 1 — single clock, rising edge.
- `reset` input 1 — asynchronous, active-low; clears all state immediately.
- `enable` input 1 — global advance. Low: all state holds and start is not accepted.
- `start` input 1 — request; sampled at a rising edge with enable=1 in IDLE.
- `op` input 3 — 000 NOP, 001 LOAD, 010 SLL, 011 SRL, 100 SRA, 101 ROL, 110 ROR, 111 SIN (shift left, insert serial_in at bit 0).
- `amount` input AMT_W — number of single-bit steps, 0..WIDTH-1.
- `data_in` input WIDTH — parallel load value for LOAD.
- `serial_in` input 1 — bit inserted by SIN; sampled on each step.
- `data_out` output WIDTH — register contents.
- `serial_out` output 1 — bit shifted or rotated out by the most recent step.
- `busy` output 1 — a multi-step operation is in progress.
- `done` output 1 — one-cycle pulse when an operation completes.

## Operation
- States: IDLE and SHIFT. In SHIFT, `op` is latched in `op_q` and `amount` in `cnt`.
- Acceptance in IDLE, at an edge with `enable`=1 and `start`=1:
  - NOP: no effect; no done pulse.
  - LOAD: data_out<=data_in; done<=1; stay in IDLE.
  - Shift op, amount=0: data_out unchanged; done<=1; stay in IDLE.
  - Shift op, amount=N≥1: latch op_q and cnt=N; busy<=1; go to SHIFT. No step is taken at the acceptance edge.
- In SHIFT, each edge with `enable`=1 performs one step of op_q, and cnt decrements:
  - SLL: {d[W-2:0],0}, out d[W-1].
  - SRL: {0,d[W-1:1]}, out d[0].
  - SRA: {d[W-1],d[W-1:1]}, out d[0].
  - ROL: {d[W-2:0],d[W-1]}, out d[W-1].
  - ROR: {d[0],d[W-1:1]}, out d[0].
  - SIN: {d[W-2:0],serial_in}, out d[W-1].
- The step that takes cnt to 0 is the final step. At that same edge: busy<=0, done<=1, go to IDLE.
- Edges with `enable`=0 in SHIFT: full stall. data_out, cnt, busy and serial_out hold.
- `start` while busy: ignored, not queued. `op`, `amount` and `data_in` changes in SHIFT have no effect.
- `done` clears at the next rising edge regardless of `enable`.
- `serial_out` changes only on shift steps; LOAD does not change it.

## Timing
- Reset (reset=0, asynchronous): data_out=0, serial_out=0, busy=0, done=0, state IDLE, cnt=0.
- Reset mid-SHIFT: the operation is aborted and all outputs take reset values. After release, the first start is accepted normally.
- LOAD and amount-0 latency: result and done are visible in the cycle after the acceptance edge.
- Amount N≥1 with enable held high:
  - busy is high for N cycles.
  - data_out shows j steps applied after acceptance edge + j.
  - The final result and done=1 are visible together after edge N.
  - Each stalled cycle adds exactly one cycle.
- Back-to-back: a start presented while done=1 is accepted, since the state is already IDLE. No dead cycle between operations.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset: drive reset=0 mid-cycle -> data_out=0x00, busy=0, done=0, serial_out=0 immediately, without waiting for a clock edge.
- LOAD 0xA5, then SLL amount=3 -> busy high 3 cycles; data_out 0x4A, 0x94, 0x28; done high with 0x28; serial_out=1.
- LOAD 0x96, then SRA amount=2 -> data_out=0xE5, serial_out=1. Separately, LOAD 0x96, SRL amount=2 -> 0x25.
- LOAD 0x81, then ROR amount=1 -> 0xC0, serial_out=1. Separately, LOAD 0x81, ROL amount=7 -> 0xC0, done after 7 steps.
- LOAD 0x00, then SIN amount=4 with serial_in=1 -> 0x0F. Then drop enable for 2 cycles inside a SIN amount=4 -> 2 extra busy cycles and identical final value.
- Each of the following applied during SLL amount=5 from 0x01:
  - start and op=LOAD asserted while busy -> ignored.
  - Back-to-back start in the done cycle -> accepted.
  - reset asserted at step 2 -> 0x00 and idle; next SLL from a fresh LOAD works.
